// File: rtl/spram_pkg.sv
// rtl/spram_pkg.sv - shared widths, power-state encoding and byte-mask helper for the SPRAM controller
// Purpose: common types used by spram_ctrl and spram_rsp_fifo.
// Contents: ADDR_W/DATA_W widths, pwr_state_e encoding, be_to_mask().
package spram_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    STBY   = 2'd1,
    SLP    = 2'd2,
    WAKE   = 2'd3
  } pwr_state_e;

  // SPRAM masks per nibble; each byte enable covers two nibbles.
  function automatic logic [3:0] be_to_mask(input logic [1:0] be);
    return {be[1], be[1], be[0], be[0]};
  endfunction

endpackage

// File: rtl/spram_rsp_fifo.sv
// rtl/spram_rsp_fifo.sv - 2-entry response buffer for SPRAM read data
// Purpose: holds captured read data until the consumer accepts it.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   i_push      write i_wdata into the tail (never asserted when full)
//   i_wdata     data to store
//   i_pop       drop the head entry (only asserted when o_valid)
//   o_valid     at least one entry present
//   o_rdata     head entry
//   o_count     number of entries held (0..2)
module spram_rsp_fifo
  import spram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_rdata,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/spram_ctrl.sv
// rtl/spram_ctrl.sv - request/response controller and power manager for one iCE40 UP SPRAM
// Purpose: turns a valid/ready request stream into SPRAM port cycles, buffers
// read data in a 2-deep FIFO and drives STANDBY/SLEEP with wake-up delays.
// Ports:
//   clk, rst_n                       clock (also SPRAM CLOCK), async active-low reset
//   req_valid/req_ready              request handshake
//   req_we, req_addr, req_wdata, req_be  request payload (be used for writes)
//   rsp_valid/rsp_ready, rsp_rdata   read response stream
//   sleep_req                        level request for SLEEP mode
//   pwr_state                        current pwr_state_e
//   ram_addr, ram_wdata, ram_maskwren, ram_wren, ram_cs,
//   ram_standby, ram_sleep, ram_poweroff  registered SPRAM controls
//   ram_rdata                        SPRAM DATAOUT
module spram_ctrl
  import spram_pkg::*;
#(
  parameter int IDLE_TIMEOUT     = 64,
  parameter int WAKE_STANDBY_CYC = 1,
  parameter int WAKE_SLEEP_CYC   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              sleep_req,
  output logic [1:0]        pwr_state,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_maskwren,
  output logic              ram_wren,
  output logic              ram_cs,
  output logic              ram_standby,
  output logic              ram_sleep,
  output logic              ram_poweroff,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam bit         IDLE_EN     = (IDLE_TIMEOUT != 0);
  localparam logic [15:0] IDLE_LAST  = 16'(IDLE_TIMEOUT - 1);
  localparam logic [7:0] WAKE_STBY_N = 8'(WAKE_STANDBY_CYC);
  localparam logic [7:0] WAKE_SLP_N  = 8'(WAKE_SLEEP_CYC);

  pwr_state_e        r_state;
  logic [15:0]       r_idle_cnt;
  logic [7:0]        r_wake_cnt;
  logic              r_run;
  logic              r_rd_s1;     // read addressed this cycle (SPRAM samples at next edge)
  logic              r_rd_s2;     // DATAOUT valid this cycle, pushed at next edge
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [3:0]        r_ram_maskwren;
  logic              r_ram_wren;
  logic              r_ram_cs;
  logic              r_ram_standby;
  logic              r_ram_sleep;

  logic [1:0]        w_fifo_count;
  logic [1:0]        w_inflight;
  logic              w_credit_ok;
  logic              w_accept;
  logic              w_pop;

  // Reads reserve a FIFO slot from issue, so the FIFO can never overflow.
  assign w_inflight  = {1'b0, r_rd_s1} + {1'b0, r_rd_s2};
  assign w_credit_ok = ({1'b0, w_fifo_count} + {1'b0, w_inflight}) < 3'd2;
  // r_run keeps req_ready low until the first clock after reset release.
  assign req_ready   = r_run && (r_state == ACTIVE) && (req_we || w_credit_ok);
  assign w_accept    = req_valid && req_ready;
  assign w_pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run          <= 1'b0;
      r_rd_s1        <= 1'b0;
      r_rd_s2        <= 1'b0;
      r_ram_addr     <= '0;
      r_ram_wdata    <= '0;
      r_ram_maskwren <= 4'd0;
      r_ram_wren     <= 1'b0;
      r_ram_cs       <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_rd_s1 <= w_accept && !req_we;
      r_rd_s2 <= r_rd_s1;
      if (w_accept) begin
        r_ram_addr     <= req_addr;
        r_ram_wdata    <= req_wdata;
        r_ram_wren     <= req_we;
        r_ram_maskwren <= req_we ? be_to_mask(req_be) : 4'd0;
        // A write with no byte enables still takes its slot but never touches the macro.
        r_ram_cs       <= !req_we || (req_be != 2'b00);
      end else begin
        r_ram_wren <= 1'b0;
        r_ram_cs   <= 1'b0;
      end
    end
  end

  // Power FSM. Low-power entry waits for no accept and no in-flight read, so
  // a pending SPRAM cycle is always sampled before STANDBY/SLEEP rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ACTIVE;
      r_idle_cnt    <= 16'd0;
      r_wake_cnt    <= 8'd0;
      r_ram_standby <= 1'b0;
      r_ram_sleep   <= 1'b0;
    end else begin
      case (r_state)
        ACTIVE: begin
          if (w_accept) begin
            r_idle_cnt <= 16'd0;
          end else if (w_inflight == 2'd0) begin
            if (sleep_req) begin
              r_state     <= SLP;
              r_ram_sleep <= 1'b1;
              r_idle_cnt  <= 16'd0;
            end else if (IDLE_EN && (r_idle_cnt == IDLE_LAST)) begin
              r_state       <= STBY;
              r_ram_standby <= 1'b1;
              r_idle_cnt    <= 16'd0;
            end else if (IDLE_EN) begin
              r_idle_cnt <= r_idle_cnt + 16'd1;
            end
          end
        end
        STBY: begin
          if (sleep_req) begin
            r_state       <= SLP;
            r_ram_standby <= 1'b0;
            r_ram_sleep   <= 1'b1;
          end else if (req_valid) begin
            r_ram_standby <= 1'b0;
            r_wake_cnt    <= WAKE_STBY_N;
            r_state       <= (WAKE_STBY_N == 8'd0) ? ACTIVE : WAKE;
          end
        end
        SLP: begin
          if (!sleep_req) begin
            r_ram_sleep <= 1'b0;
            r_wake_cnt  <= WAKE_SLP_N;
            r_state     <= (WAKE_SLP_N == 8'd0) ? ACTIVE : WAKE;
          end
        end
        WAKE: begin
          // One WAKE cycle per count; the last one hands back to ACTIVE.
          if (r_wake_cnt <= 8'd1) begin
            r_wake_cnt <= 8'd0;
            r_state    <= ACTIVE;
          end else begin
            r_wake_cnt <= r_wake_cnt - 8'd1;
          end
        end
        default: r_state <= ACTIVE;
      endcase
    end
  end

  spram_rsp_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_rd_s2),
    .i_wdata (ram_rdata),
    .i_pop   (w_pop),
    .o_valid (rsp_valid),
    .o_rdata (rsp_rdata),
    .o_count (w_fifo_count)
  );

  assign pwr_state    = r_state;
  assign ram_addr     = r_ram_addr;
  assign ram_wdata    = r_ram_wdata;
  assign ram_maskwren = r_ram_maskwren;
  assign ram_wren     = r_ram_wren;
  assign ram_cs       = r_ram_cs;
  assign ram_standby  = r_ram_standby;
  assign ram_sleep    = r_ram_sleep;
  // The macro is never powered off by this controller.
  assign ram_poweroff = 1'b1;

endmodule

// File: tb/SB_SPRAM256KA.sv
// tb/SB_SPRAM256KA.sv - behavioural model of the iCE40 UP 16K x 16 SPRAM macro
module SB_SPRAM256KA (
  input  logic [13:0] ADDRESS,
  input  logic [15:0] DATAIN,
  input  logic [3:0]  MASKWREN,
  input  logic        WREN,
  input  logic        CHIPSELECT,
  input  logic        CLOCK,
  input  logic        STANDBY,
  input  logic        SLEEP,
  input  logic        POWEROFF,
  output logic [15:0] DATAOUT
);

  logic [15:0] mem [0:16383];
  logic        bad_access = 1'b0;

  always @(posedge CLOCK) begin
    if (CHIPSELECT && (STANDBY || SLEEP || !POWEROFF)) begin
      bad_access <= 1'b1;
    end else if (CHIPSELECT) begin
      if (WREN) begin
        if (MASKWREN[0]) mem[ADDRESS][3:0]   <= DATAIN[3:0];
        if (MASKWREN[1]) mem[ADDRESS][7:4]   <= DATAIN[7:4];
        if (MASKWREN[2]) mem[ADDRESS][11:8]  <= DATAIN[11:8];
        if (MASKWREN[3]) mem[ADDRESS][15:12] <= DATAIN[15:12];
      end else begin
        DATAOUT <= mem[ADDRESS];
      end
    end
  end

endmodule

// File: tb/tb_spram_ctrl.sv
// tb/tb_spram_ctrl.sv - directed scoreboard bench for spram_ctrl against an SPRAM model
module tb_spram_ctrl;
  import spram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [13:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_rdata;
  logic        sleep_req;
  logic [1:0]  pwr_state;
  logic [13:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata;
  logic [3:0]  ram_maskwren;
  logic        ram_wren, ram_cs, ram_standby, ram_sleep, ram_poweroff;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mdl [0:16383];
  logic [15:0] last_rsp = 16'h0;
  int          rsp_seen = 0;
  int          nw, nv, rs0;

  always #5 clk = ~clk;

  spram_ctrl #(.IDLE_TIMEOUT(8), .WAKE_STANDBY_CYC(1), .WAKE_SLEEP_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sleep_req(sleep_req), .pwr_state(pwr_state),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_maskwren(ram_maskwren),
    .ram_wren(ram_wren), .ram_cs(ram_cs), .ram_standby(ram_standby),
    .ram_sleep(ram_sleep), .ram_poweroff(ram_poweroff), .ram_rdata(ram_rdata)
  );

  SB_SPRAM256KA u_ram (
    .ADDRESS(ram_addr), .DATAIN(ram_wdata), .MASKWREN(ram_maskwren),
    .WREN(ram_wren), .CHIPSELECT(ram_cs), .CLOCK(clk),
    .STANDBY(ram_standby), .SLEEP(ram_sleep), .POWEROFF(ram_poweroff),
    .DATAOUT(ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected read data queued at accept, compared at pop.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid && rsp_ready) begin
        rsp_seen++;
        last_rsp = rsp_rdata;
        if (exp_q.size() == 0) begin
          total++;
          assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL rsp_unexpected observed=%0h expected=none", rsp_rdata);
          end
        end else begin
          chk("rsp_data", 32'(rsp_rdata), 32'(exp_q.pop_front()));
        end
      end
      if (req_valid && req_ready) begin
        if (req_we) begin
          if (req_be[0]) mdl[req_addr][7:0]  = req_wdata[7:0];
          if (req_be[1]) mdl[req_addr][15:8] = req_wdata[15:8];
        end else begin
          exp_q.push_back(mdl[req_addr]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [13:0] a, input logic [15:0] d,
                           input logic [1:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
  endtask

  task automatic wait_accept(input string tag);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 30 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk(tag, 32'(acc), 32'd1);
  endtask

  task automatic do_req(input logic we, input logic [13:0] a, input logic [15:0] d,
                        input logic [1:0] be, input string tag);
    drive_req(we, a, d, be);
    wait_accept(tag);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 40) begin
      tick();
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = 2'b00; rsp_ready = 1'b1; sleep_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_ram_cs", 32'(ram_cs), 32'd0);
    chk("rst_ram_wren", 32'(ram_wren), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_ram_mask", 32'(ram_maskwren), 32'd0);
    chk("rst_ram_standby", 32'(ram_standby), 32'd0);
    chk("rst_ram_sleep", 32'(ram_sleep), 32'd0);
    chk("rst_ram_poweroff", 32'(ram_poweroff), 32'd1);
    chk("rst_pwr_state", 32'(pwr_state), 32'(ACTIVE));
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_state", 32'(pwr_state), 32'(ACTIVE));

    // Full write then read with latency check.
    do_req(1'b1, 14'h0010, 16'hA5C3, 2'b11, "acc_wr_full");
    chk("wr_cs", 32'(ram_cs), 32'd1);
    chk("wr_wren", 32'(ram_wren), 32'd1);
    chk("wr_mask", 32'(ram_maskwren), 32'hF);
    chk("wr_addr", 32'(ram_addr), 32'h0010);
    chk("wr_data", 32'(ram_wdata), 32'hA5C3);
    do_req(1'b0, 14'h0010, 16'h0, 2'b00, "acc_rd_full");
    chk("rd_cs", 32'(ram_cs), 32'd1);
    chk("rd_wren", 32'(ram_wren), 32'd0);
    chk("lat_c0", 32'(rsp_valid), 32'd0);
    tick();
    chk("lat_c1", 32'(rsp_valid), 32'd0);
    tick();
    chk("lat_c2", 32'(rsp_valid), 32'd1);
    wait_drain();
    chk("rd_full_val", 32'(last_rsp), 32'hA5C3);

    // Partial write, then a write with no byte enables.
    do_req(1'b1, 14'h0010, 16'h1234, 2'b01, "acc_wr_part");
    chk("part_cs", 32'(ram_cs), 32'd1);
    chk("part_mask", 32'(ram_maskwren), 32'h3);
    do_req(1'b0, 14'h0010, 16'h0, 2'b00, "acc_rd_part");
    wait_drain();
    chk("part_val", 32'(last_rsp), 32'hA534);
    do_req(1'b1, 14'h0010, 16'h1234, 2'b00, "acc_wr_be0");
    chk("be0_cs", 32'(ram_cs), 32'd0);
    do_req(1'b0, 14'h0010, 16'h0, 2'b00, "acc_rd_be0");
    wait_drain();
    chk("be0_val", 32'(last_rsp), 32'hA534);

    // Credit limit under response backpressure.
    do_req(1'b1, 14'h0001, 16'h1111, 2'b11, "acc_wr1");
    do_req(1'b1, 14'h0002, 16'h2222, 2'b11, "acc_wr2");
    do_req(1'b1, 14'h0003, 16'h3333, 2'b11, "acc_wr3");
    rs0 = rsp_seen;
    rsp_ready = 1'b0;
    do_req(1'b0, 14'h0001, 16'h0, 2'b00, "acc_bp1");
    do_req(1'b0, 14'h0002, 16'h0, 2'b00, "acc_bp2");
    drive_req(1'b0, 14'h0003, 16'h0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_head", 32'(rsp_rdata), 32'h1111);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    wait_accept("acc_bp3");
    rsp_ready = 1'b1;
    wait_drain();
    chk("bp_last", 32'(last_rsp), 32'h3333);
    chk("bp_count", 32'(rsp_seen - rs0), 32'd3);

    // Auto-standby after 8 idle cycles, then wake on a read.
    do_req(1'b1, 14'h0020, 16'h5A5A, 2'b11, "acc_wr_sb");
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("sb_not_yet", 32'(ram_standby), 32'd0);
    end
    tick();
    chk("sb_on", 32'(ram_standby), 32'd1);
    chk("sb_state", 32'(pwr_state), 32'(STBY));
    drive_req(1'b0, 14'h0020, 16'h0, 2'b00);
    tick();
    chk("sb_off", 32'(ram_standby), 32'd0);
    chk("sb_wake", 32'(pwr_state), 32'(WAKE));
    chk("sb_wake_rdy", 32'(req_ready), 32'd0);
    tick();
    chk("sb_rdy", 32'(req_ready), 32'd1);
    wait_accept("acc_rd_sb");
    wait_drain();
    chk("sb_val", 32'(last_rsp), 32'h5A5A);

    // Sleep request during a read; sleep only after capture.
    do_req(1'b0, 14'h0010, 16'h0, 2'b00, "acc_rd_slp");
    sleep_req = 1'b1;
    tick();
    chk("slp_wait1", 32'(ram_sleep), 32'd0);
    tick();
    chk("slp_wait2", 32'(ram_sleep), 32'd0);
    chk("slp_capture", 32'(rsp_valid), 32'd1);
    tick();
    chk("slp_on", 32'(ram_sleep), 32'd1);
    chk("slp_state", 32'(pwr_state), 32'(SLP));
    repeat (3) tick();
    chk("slp_hold", 32'(pwr_state), 32'(SLP));
    chk("slp_rdy", 32'(req_ready), 32'd0);
    sleep_req = 1'b0;
    tick();
    chk("slp_off", 32'(ram_sleep), 32'd0);
    nw = 0;
    for (int i = 0; i < 20; i++) begin
      if (pwr_state == ACTIVE) break;
      if (pwr_state == WAKE && !req_ready) nw++;
      tick();
    end
    chk("slp_wake_cyc", 32'(nw), 32'd4);
    chk("slp_ready", 32'(req_ready), 32'd1);
    chk("slp_val", 32'(last_rsp), 32'hA534);

    // Reset with a read in flight discards it.
    do_req(1'b0, 14'h0010, 16'h0, 2'b00, "acc_rd_rst");
    rst_n = 1'b0;
    exp_q.delete();
    nv = 0;
    repeat (2) begin
      tick();
      if (rsp_valid) nv++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid) nv++;
    end
    chk("rst_no_rsp", 32'(nv), 32'd0);
    chk("rst_state", 32'(pwr_state), 32'(ACTIVE));

    chk("no_lowpwr_access", 32'(u_ram.bad_access), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
